// File: rtl/router_pkg.sv
// Shared definitions for the router source-side blocks.
//   DATA_W / ADDR_W / LEN_W : router bus, destination and length widths
//   ADDR_INVALID            : destination code with no output port
//   framer_state_t          : packet framer states
//   make_header()           : router header byte {len, addr}
package router_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } framer_state_t;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload buffer for the packet framer: DEPTH x DATA_W register array.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : read data (zero for addresses beyond DEPTH-1)
module router_pkt_buf
    import router_pkg::*;
#(
    parameter int DEPTH = 63
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LEN_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [LEN_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            r_mem[waddr] <= wdata;
        end
    end

    // The framer prefetches one entry past the last payload byte; that
    // read falls outside the array and returns zero.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = r_mem[raddr];
        end
    end

endmodule

// File: rtl/router_pkt_framer.sv
// Upstream source stage for the 1x3 router. Takes a packet command and a
// host byte stream, buffers the whole payload, then emits header, payload
// (pkt_valid high) and parity (pkt_valid low) on the router input bus while
// honouring busy back-pressure.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_addr, cmd_len     : destination port 0..2, payload length 1..MAX_LEN
//   cmd_corrupt           : invert bit 0 of the parity byte
//   cmd_err               : one-cycle pulse when an illegal command is dropped
//   in_valid/in_data      : payload byte stream
//   in_ready              : payload accepted (LOAD only)
//   busy                  : router busy, hold the current output byte
//   data, pkt_valid       : registered router input bus
//   pkt_done              : one-cycle pulse after the parity byte transfers
//   tx_active             : high in HEADER, PAYLOAD and PARITY
module router_pkt_framer
    import router_pkg::*;
#(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_corrupt,
    output logic              cmd_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] data,
    output logic              pkt_valid,
    output logic              pkt_done,
    output logic              tx_active
);

    localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    framer_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic              r_corrupt;
    logic [LEN_W-1:0]  r_wcnt;
    logic [LEN_W-1:0]  r_rcnt;
    logic [DATA_W-1:0] r_par;
    logic [DATA_W-1:0] r_data;
    logic              r_pkt_valid;
    logic              r_cmd_err;
    logic              r_pkt_done;
    logic [GAP_W-1:0]  r_gcnt;

    logic              w_cmd_fire;
    logic              w_cmd_bad;
    logic              w_we;
    logic [LEN_W-1:0]  w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign in_ready  = (r_state == ST_LOAD);
    assign tx_active = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) ||
                       (r_state == ST_PARITY);
    assign data      = r_data;
    assign pkt_valid = r_pkt_valid;
    assign cmd_err   = r_cmd_err;
    assign pkt_done  = r_pkt_done;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_cmd_bad  = (cmd_addr == ADDR_INVALID) || (cmd_len == '0) ||
                        (int'(cmd_len) > MAX_LEN);
    assign w_we       = (r_state == ST_LOAD) && in_valid;

    // Read one byte ahead: the byte fetched here is registered onto data
    // at the edge that transfers the byte currently on the bus.
    assign w_raddr = (r_state == ST_HEADER) ? '0 : (r_rcnt + LEN_W'(1));

    router_pkt_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_wcnt),
        .wdata (in_data),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_corrupt   <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_par       <= '0;
            r_data      <= '0;
            r_pkt_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_gcnt      <= '0;
        end else begin
            r_cmd_err  <= 1'b0;
            r_pkt_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        if (w_cmd_bad) begin
                            r_cmd_err <= 1'b1;
                        end else begin
                            r_addr    <= cmd_addr;
                            r_len     <= cmd_len;
                            r_corrupt <= cmd_corrupt;
                            r_wcnt    <= '0;
                            r_par     <= make_header(cmd_len, cmd_addr);
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        r_wcnt <= r_wcnt + LEN_W'(1);
                        r_par  <= r_par ^ in_data;
                        if (r_wcnt == (r_len - LEN_W'(1))) begin
                            r_data      <= make_header(r_len, r_addr);
                            r_pkt_valid <= 1'b1;
                            r_state     <= ST_HEADER;
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        r_data  <= w_rdata;
                        r_rcnt  <= '0;
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (r_rcnt == (r_len - LEN_W'(1))) begin
                            r_data      <= r_par ^ {{(DATA_W-1){1'b0}}, r_corrupt};
                            r_pkt_valid <= 1'b0;
                            r_state     <= ST_PARITY;
                        end else begin
                            r_rcnt <= r_rcnt + LEN_W'(1);
                            r_data <= w_rdata;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        r_data     <= '0;
                        r_pkt_done <= 1'b1;
                        r_gcnt     <= '0;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gcnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_framer.sv
// Directed bench for router_pkt_framer: a table of packet commands with
// hand-computed header/parity/timing, a per-cycle byte-stream model, and
// hand-written sequences for illegal commands and reset mid-packet.
module tb_router_pkt_framer;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_corrupt;
    logic       cmd_err;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic [7:0] data;
    logic       pkt_valid;
    logic       pkt_done;
    logic       tx_active;

    int n_vec  = 0;
    int n_miss = 0;

    router_pkt_framer #(
        .MAX_LEN    (63),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_corrupt (cmd_corrupt),
        .cmd_err     (cmd_err),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .data        (data),
        .pkt_valid   (pkt_valid),
        .pkt_done    (pkt_done),
        .tx_active   (tx_active)
    );

    always #5 clk = ~clk;

    // kind: 0 = 0x11,0x22,0x33..., 1 = ramp 0,1,2..., 2 = constant 0xA5
    // bs/bl: busy asserted for bl cycles starting at cycle C+bs
    // exp_done / exp_ready: cycle offsets from command acceptance cycle C
    typedef struct {
        logic [1:0] addr;
        logic [5:0] len;
        logic       corrupt;
        int         kind;
        int         bs;
        int         bl;
        logic [7:0] exp_hdr;
        logic [7:0] exp_par;
        int         exp_done;
        int         exp_ready;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s at C+%0d: got %0h expected %0h", name, k, got, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int kind, input int i);
        if (kind == 0) return 8'((i + 1) * 17);
        if (kind == 1) return 8'(i);
        return 8'hA5;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready && w < 200) begin
            tick();
            w++;
        end
        chk("wait_cmd_ready", w, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_packet(input vec_t v);
        logic [7:0] tx[65];
        logic [7:0] par;
        logic [7:0] exp_data;
        logic       exp_pv;
        logic       active;
        logic       erdy;
        logic       b;
        int         n;
        int         p;
        int         done_at;
        bit         finished;
        n        = int'(v.len);
        p        = 0;
        done_at  = -1;
        finished = 1'b0;
        tx[0]    = {v.len, v.addr};
        par      = tx[0];
        for (int i = 0; i < n; i++) begin
            tx[i+1] = pay(v.kind, i);
            par     = par ^ tx[i+1];
        end
        tx[n+1] = par ^ {7'b0, v.corrupt};

        wait_ready();
        // Cycle C: command plus a stray payload beat that must not be taken.
        cmd_valid   = 1'b1;
        cmd_addr    = v.addr;
        cmd_len     = v.len;
        cmd_corrupt = v.corrupt;
        in_valid    = 1'b1;
        in_data     = 8'hEE;
        busy        = 1'b0;

        for (int k = 1; k <= 300 && !finished; k++) begin
            tick();
            active   = (k >= n + 1) && (p <= n + 1);
            exp_data = active ? tx[p] : 8'h00;
            exp_pv   = active && (p <= n);
            erdy     = (done_at > 0) && (k >= done_at + GAP);
            chk("data",      k, 32'(data),      32'(exp_data));
            chk("pkt_valid", k, 32'(pkt_valid), 32'(exp_pv));
            chk("tx_active", k, 32'(tx_active), 32'(active));
            chk("pkt_done",  k, 32'(pkt_done),  32'(k == done_at));
            chk("cmd_ready", k, 32'(cmd_ready), 32'(erdy));
            chk("cmd_err",   k, 32'(cmd_err),   32'd0);
            chk("in_ready",  k, 32'(in_ready),  32'(k <= n));
            if (k == n + 1)         chk("header", k, 32'(data), 32'(v.exp_hdr));
            if (active && p == n + 1) chk("parity", k, 32'(data), 32'(v.exp_par));
            if (k == v.exp_done)    chk("done_cycle",  k, 32'(pkt_done),  32'd1);
            if (k == v.exp_ready)   chk("ready_cycle", k, 32'(cmd_ready), 32'd1);
            if (erdy) finished = 1'b1;

            b = (v.bl > 0) && (k >= v.bs) && (k < v.bs + v.bl);
            busy = b;
            // Illegal command held outside IDLE: any consumption shows as cmd_err.
            cmd_valid = !erdy;
            cmd_addr  = 2'd3;
            cmd_len   = 6'd5;
            in_valid  = 1'b1;
            in_data   = (k <= n) ? pay(v.kind, k - 1) : 8'hEE;
            if (active && !b) begin
                if (p == n + 1) done_at = k + 1;
                p++;
            end
        end
        if (!finished) chk("packet_timeout", 0, 32'd0, 32'd1);
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        busy      = 1'b0;
    endtask

    task automatic run_illegal(input logic [1:0] a, input logic [5:0] l);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        cmd_valid = 1'b0;
        chk("ill_cmd_err",   1, 32'(cmd_err),   32'd1);
        chk("ill_cmd_ready", 1, 32'(cmd_ready), 32'd1);
        chk("ill_in_ready",  1, 32'(in_ready),  32'd0);
        chk("ill_pkt_valid", 1, 32'(pkt_valid), 32'd0);
        chk("ill_tx_active", 1, 32'(tx_active), 32'd0);
        tick();
        chk("ill_cmd_err2",   2, 32'(cmd_err),   32'd0);
        chk("ill_in_ready2",  2, 32'(in_ready),  32'd0);
        chk("ill_pkt_valid2", 2, 32'(pkt_valid), 32'd0);
        chk("ill_cmd_ready2", 2, 32'(cmd_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_reset_mid();
        wait_ready();
        cmd_valid   = 1'b1;
        cmd_addr    = 2'd1;
        cmd_len     = 6'd3;
        cmd_corrupt = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            cmd_valid = 1'b0;
            in_valid  = (k <= 3);
            in_data   = pay(0, k - 1);
        end
        chk("rm_second_byte", 6, 32'(data),      32'h22);
        chk("rm_pkt_valid",   6, 32'(pkt_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rm_rst_pkt_valid", 7, 32'(pkt_valid), 32'd0);
        chk("rm_rst_data",      7, 32'(data),      32'h00);
        chk("rm_rst_pkt_done",  7, 32'(pkt_done),  32'd0);
        chk("rm_rst_tx_active", 7, 32'(tx_active), 32'd0);
        chk("rm_rst_cmd_ready", 7, 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        for (int k = 8; k <= 10; k++) begin
            tick();
            chk("rm_no_pkt_done", k, 32'(pkt_done),  32'd0);
            chk("rm_idle_pv",     k, 32'(pkt_valid), 32'd0);
            chk("rm_cmd_ready",   k, 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'd1, 6'd3,  1'b0, 0, 0, 0, 8'h0D, 8'h0D, 9,   11};
        tbl[1] = '{2'd1, 6'd3,  1'b0, 0, 6, 3, 8'h0D, 8'h0D, 12,  14};
        tbl[2] = '{2'd1, 6'd3,  1'b1, 0, 0, 0, 8'h0D, 8'h0C, 9,   11};
        // 0xFE ^ (0 ^ 1 ^ ... ^ 62) = 0xFE ^ 0x3F
        tbl[3] = '{2'd2, 6'd63, 1'b0, 1, 0, 0, 8'hFE, 8'hC1, 129, 131};
        // busy during LOAD, then during GAP: neither may shift anything
        tbl[4] = '{2'd0, 6'd1,  1'b0, 2, 1, 1, 8'h04, 8'hA1, 5,   7};
        tbl[5] = '{2'd0, 6'd1,  1'b0, 2, 5, 2, 8'h04, 8'hA1, 5,   7};

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = 2'd0;
        cmd_len     = 6'd0;
        cmd_corrupt = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        busy        = 1'b1;
        tick();
        tick();
        chk("rst_data",      0, 32'(data),      32'h00);
        chk("rst_pkt_valid", 0, 32'(pkt_valid), 32'd0);
        chk("rst_cmd_err",   0, 32'(cmd_err),   32'd0);
        chk("rst_pkt_done",  0, 32'(pkt_done),  32'd0);
        chk("rst_tx_active", 0, 32'(tx_active), 32'd0);
        chk("rst_in_ready",  0, 32'(in_ready),  32'd0);
        chk("rst_cmd_ready", 0, 32'(cmd_ready), 32'd0);
        rst  = 1'b0;
        busy = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 0, 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_packet(tbl[i]);
        end
        run_illegal(2'd3, 6'd5);
        run_illegal(2'd1, 6'd0);
        run_reset_mid();
        run_packet(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
